// File: rtl/tug_of_war_match.sv
// Tug-of-war playfield with multi-round match scoring.
// A one-hot rope LED moves toward the pressing player; pulling it off an end
// scores a point, the rope holds at that end for HOLD_CYCLES edges, then
// recentres. The first player to WIN_SCORE points ends the match until reset.
module tug_of_war_match #(
  parameter int NUM_LEDS    = 9,
  parameter int START_POS   = 4,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Rin,
  input  logic                Lin,
  output logic [NUM_LEDS-1:0] LED,
  output logic [SCORE_W-1:0]  left_score,
  output logic [SCORE_W-1:0]  right_score,
  output logic                point_l,
  output logic                point_r,
  output logic                match_over,
  output logic                match_winner
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0]  WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [NUM_LEDS-1:0] START_LED = {{(NUM_LEDS-1){1'b0}}, 1'b1} << START_POS;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    POINT      = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [HOLD_W-1:0]   hold, hold_n;
  logic [NUM_LEDS-1:0] led_n;
  logic [SCORE_W-1:0]  left_n, right_n;
  logic [SCORE_W-1:0]  left_inc, right_inc;
  logic                point_l_n, point_r_n;
  logic                over_n, winner_n;
  logic                pull_r, pull_l;

  // Simultaneous presses cancel; only a lone press moves the rope.
  assign pull_r    = Rin & ~Lin;
  assign pull_l    = Lin & ~Rin;
  assign left_inc  = left_score + 1'b1;
  assign right_inc = right_score + 1'b1;

  // State register and all registered outputs; reset overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PLAY;
      hold         <= '0;
      LED          <= START_LED;
      left_score   <= '0;
      right_score  <= '0;
      point_l      <= 1'b0;
      point_r      <= 1'b0;
      match_over   <= 1'b0;
      match_winner <= 1'b0;
    end else begin
      state        <= state_n;
      hold         <= hold_n;
      LED          <= led_n;
      left_score   <= left_n;
      right_score  <= right_n;
      point_l      <= point_l_n;
      point_r      <= point_r_n;
      match_over   <= over_n;
      match_winner <= winner_n;
    end
  end

  // Next-state and next-output logic: move, score, hold, or stay frozen.
  always_comb begin
    state_n   = state;
    hold_n    = hold;
    led_n     = LED;
    left_n    = left_score;
    right_n   = right_score;
    point_l_n = 1'b0;
    point_r_n = 1'b0;
    over_n    = match_over;
    winner_n  = match_winner;
    case (state)
      PLAY: begin
        if (pull_r) begin
          if (LED[0]) begin
            // Rope already at the right end: score, LED stays put.
            right_n   = right_inc;
            point_r_n = 1'b1;
            if (right_inc == WIN) begin
              state_n  = MATCH_OVER;
              over_n   = 1'b1;
              winner_n = 1'b0;
            end else begin
              state_n = POINT;
              hold_n  = '0;
            end
          end else begin
            led_n = LED >> 1;
          end
        end else if (pull_l) begin
          if (LED[NUM_LEDS-1]) begin
            left_n    = left_inc;
            point_l_n = 1'b1;
            if (left_inc == WIN) begin
              state_n  = MATCH_OVER;
              over_n   = 1'b1;
              winner_n = 1'b1;
            end else begin
              state_n = POINT;
              hold_n  = '0;
            end
          end else begin
            led_n = LED << 1;
          end
        end
      end
      POINT: begin
        // Presses are dropped here; recentre on the HOLD_CYCLES-th edge.
        if (hold == HOLD_LAST) begin
          led_n   = START_LED;
          state_n = PLAY;
          hold_n  = '0;
        end else begin
          hold_n = hold + 1'b1;
        end
      end
      MATCH_OVER: begin
        // Terminal until reset.
      end
      default: begin
        state_n = PLAY;
        led_n   = START_LED;
      end
    endcase
  end

endmodule

// File: tb/tb_tug_of_war_match.sv
// Scoreboard bench for tug_of_war_match: the stimulus process drives one
// cycle at a time, advances an abstract game model and queues the expected
// outputs; a monitor pops and compares after every active clock edge.
module tb_tug_of_war_match;

  localparam int NUM_LEDS    = 9;
  localparam int START_POS   = 4;
  localparam int SCORE_W     = 3;
  localparam int WIN_SCORE   = 7;
  localparam int HOLD_CYCLES = 4;

  typedef struct packed {
    logic [NUM_LEDS-1:0] led;
    logic [SCORE_W-1:0]  ls;
    logic [SCORE_W-1:0]  rs;
    logic                pl;
    logic                pr;
    logic                mo;
    logic                mw;
  } obs_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                Rin = 1'b0;
  logic                Lin = 1'b0;
  logic [NUM_LEDS-1:0] LED;
  logic [SCORE_W-1:0]  left_score;
  logic [SCORE_W-1:0]  right_score;
  logic                point_l;
  logic                point_r;
  logic                match_over;
  logic                match_winner;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  obs_t expq[$];

  // Abstract game model: rope index, scores, phase (0 play, 1 hold, 2 over)
  int m_pos, m_ls, m_rs, m_phase, m_hold_left;
  bit m_pl, m_pr, m_mo, m_mw;

  tug_of_war_match #(
    .NUM_LEDS(NUM_LEDS), .START_POS(START_POS), .SCORE_W(SCORE_W),
    .WIN_SCORE(WIN_SCORE), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .Rin(Rin), .Lin(Lin), .LED(LED),
    .left_score(left_score), .right_score(right_score),
    .point_l(point_l), .point_r(point_r),
    .match_over(match_over), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit r, input bit l, input bit rst);
    m_pl = 1'b0;
    m_pr = 1'b0;
    if (rst) begin
      m_pos = START_POS; m_ls = 0; m_rs = 0; m_phase = 0;
      m_hold_left = 0; m_mo = 1'b0; m_mw = 1'b0;
    end else if (m_phase == 0) begin
      if (r && !l) begin
        if (m_pos == 0) begin
          m_rs++; m_pr = 1'b1;
          if (m_rs == WIN_SCORE) begin m_phase = 2; m_mo = 1'b1; m_mw = 1'b0; end
          else begin m_phase = 1; m_hold_left = HOLD_CYCLES; end
        end else m_pos--;
      end else if (l && !r) begin
        if (m_pos == NUM_LEDS - 1) begin
          m_ls++; m_pl = 1'b1;
          if (m_ls == WIN_SCORE) begin m_phase = 2; m_mo = 1'b1; m_mw = 1'b1; end
          else begin m_phase = 1; m_hold_left = HOLD_CYCLES; end
        end else m_pos++;
      end
    end else if (m_phase == 1) begin
      m_hold_left--;
      if (m_hold_left == 0) begin m_pos = START_POS; m_phase = 0; end
    end
  endtask

  task automatic step(input bit r, input bit l, input bit rst);
    obs_t e;
    @(negedge clk);
    Rin = r; Lin = l; reset = rst;
    model_edge(r, l, rst);
    e.led = NUM_LEDS'(1) << m_pos;
    e.ls  = SCORE_W'(m_ls);
    e.rs  = SCORE_W'(m_rs);
    e.pl  = m_pl; e.pr = m_pr; e.mo = m_mo; e.mw = m_mw;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_r(input int n);
    for (int i = 0; i < n; i++) begin step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); end
  endtask

  task automatic press_l(input int n);
    for (int i = 0; i < n; i++) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
  endtask

  // Monitor: outputs are valid every cycle, so compare one entry per edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {LED, left_score, right_score, point_l, point_r, match_over, match_winner};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle%0d: got LED=%b L=%0d R=%0d pl=%b pr=%b mo=%b mw=%b, want LED=%b L=%0d R=%0d pl=%b pr=%b mo=%b mw=%b",
                   cyc, a.led, a.ls, a.rs, a.pl, a.pr, a.mo, a.mw,
                   e.led, e.ls, e.rs, e.pl, e.pr, e.mo, e.mw);
        end
        cyc++;
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pr_pct, pl_pct;
    // T1: reset for two cycles, then a single-cycle reset
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(1);
    // T2: move right, move back, simultaneous press holds
    press_r(1);
    press_l(1);
    step(1'b1, 1'b1, 1'b0);
    idle(1);
    // T3: right point, presses during the hold are dropped
    press_r(4);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    // T4: left edge, simultaneous press at the edge, then left point
    press_l(4);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(HOLD_CYCLES + 1);
    // T6: reset during the second POINT cycle
    press_l(5);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    // T5: left wins a full match, then everything is frozen
    for (int p = 0; p < WIN_SCORE; p++) begin
      press_l(5);
      idle(HOLD_CYCLES);
    end
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'($urandom), 1'b0);
    step(1'b0, 1'b0, 1'b1);
    // Right player wins a match, with a stray press mid-hold each point
    for (int p = 0; p < WIN_SCORE; p++) begin
      press_r(5);
      step(1'b0, 1'b1, 1'b0);
      idle(HOLD_CYCLES);
    end
    idle(3);
    // Randomised play with biased phases and occasional resets
    step(1'b0, 1'b0, 1'b1);
    for (int blk = 0; blk < 16; blk++) begin
      pr_pct = $urandom_range(10, 70);
      pl_pct = $urandom_range(10, 70);
      for (int i = 0; i < 250; i++)
        step($urandom_range(0, 99) < pr_pct, $urandom_range(0, 99) < pl_pct,
             $urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    Rin = 1'b0; Lin = 1'b0; reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
